// File: rtl/cpu_pkg.sv
// Shared CPU package: memory geometry, instruction width, the NOP encoding,
// the default reset PC and the major opcodes used by decode.
package cpu_pkg;

  localparam int          IMEM_ADDR_W = 10;
  localparam int          INSTR_W     = 32;
  localparam int unsigned RESET_PC    = 0;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  // Major opcodes (instr[6:0]) consumed by decode.
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
// Ports: clk, reset (sync, active high), inc, count[WIDTH-1:0].
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational
// instruction memory and captures the returned word into IF/ID.
// Edge priority: reset > redirect > stall > advance.
// Ports:
//   clk, reset            clock, sync active-high reset
//   stall                 hold PC and IF/ID
//   redirect_valid/_pc    taken branch/jump target (bits [1:0] ignored)
//   imem_addr/imem_data   instruction memory port (imem_addr == pc)
//   if_id_*               IF/ID register outputs
//   fetch_cnt/stall_cnt   saturating bring-up counters
module fetch_stage #(
  parameter int          ADDR_W   = cpu_pkg::IMEM_ADDR_W,
  parameter int unsigned RESET_PC = cpu_pkg::RESET_PC,
  parameter int          CNT_W    = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        redirect_valid,
  input  logic [ADDR_W-1:0]           redirect_pc,
  output logic [ADDR_W-1:0]           imem_addr,
  input  logic [cpu_pkg::INSTR_W-1:0] imem_data,
  output logic [cpu_pkg::INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]           if_id_pc,
  output logic [ADDR_W-1:0]           if_id_pc_plus4,
  output logic                        if_id_valid,
  output logic [CNT_W-1:0]            fetch_cnt,
  output logic [CNT_W-1:0]            stall_cnt
);
  import cpu_pkg::*;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic              advance;
  logic              stall_hold;
  logic              unused_redirect_lsbs;

  // Wraps modulo 2^ADDR_W by width truncation.
  assign pc_plus4  = pc + ADDR_W'(4);
  assign imem_addr = pc;

  // Redirect beats stall, so a stalled cycle only counts when no redirect.
  assign advance    = !reset && !redirect_valid && !stall;
  assign stall_hold = !reset && !redirect_valid &&  stall;

  // Targets are forced word-aligned; the low bits are deliberately dropped.
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      pc             <= ADDR_W'(RESET_PC);
      if_id_instr    <= NOP_INSTR;
      if_id_pc       <= '0;
      if_id_pc_plus4 <= '0;
      if_id_valid    <= 1'b0;
    end else if (redirect_valid) begin
      // One bubble: the instruction at the old PC is squashed.
      pc             <= {redirect_pc[ADDR_W-1:2], 2'b00};
      if_id_instr    <= NOP_INSTR;
      if_id_pc       <= '0;
      if_id_pc_plus4 <= '0;
      if_id_valid    <= 1'b0;
    end else if (!stall) begin
      pc             <= pc_plus4;
      if_id_instr    <= imem_data;
      if_id_pc       <= pc;
      if_id_pc_plus4 <= pc_plus4;
      if_id_valid    <= 1'b1;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_fetch_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (advance),
    .count (fetch_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_hold),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: each driven cycle pushes the expected
// IF/ID contents; a negedge monitor pops and compares every cycle.
module tb_fetch_stage;

  localparam int AW = 10;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic [31:0]   if_id_instr;
  logic [AW-1:0] if_id_pc;
  logic [AW-1:0] if_id_pc_plus4;
  logic          if_id_valid;
  logic [CW-1:0] fetch_cnt;
  logic [CW-1:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic          valid;
    logic [31:0]   instr;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc4;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  // Memory word is a recognisable tag plus its own byte address.
  function automatic logic [31:0] memword(input logic [AW-1:0] a);
    return {16'hC0DE, 6'h0, a};
  endfunction

  assign imem_data = memword(imem_addr);

  fetch_stage #(.ADDR_W(AW), .RESET_PC(0), .CNT_W(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .fetch_cnt      (fetch_cnt),
    .stall_cnt      (stall_cnt)
  );

  // Monitor: one expectation per clock edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_tests++;
      if (if_id_valid !== e.valid || if_id_instr !== e.instr ||
          if_id_pc !== e.pc || if_id_pc_plus4 !== e.pc4) begin
        n_fail++;
        $display("FAIL ifid @%0t: got v=%0b i=%h pc=%h pc4=%h, want v=%0b i=%h pc=%h pc4=%h",
                 $time, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4,
                 e.valid, e.instr, e.pc, e.pc4);
      end
    end
  end

  task automatic chk(input string name, input int act, input int want);
    n_tests++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  // Drive one cycle; ev/ep describe IF/ID after the coming edge.
  task automatic step(input logic rst, input logic s, input logic rv,
                      input logic [AW-1:0] rpc, input logic ev,
                      input logic [AW-1:0] ep);
    exp_t e;
    reset          = rst;
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    e.valid = ev;
    e.instr = ev ? memword(ep) : 32'h0;
    e.pc    = ev ? ep : '0;
    e.pc4   = ev ? AW'(ep + AW'(4)) : '0;
    sb_q.push_back(e);
    @(negedge clk);
    #2;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " imem_addr"}, int'(imem_addr), 0);
    chk({tag, " instr"},     int'(if_id_instr), 0);
    chk({tag, " pc"},        int'(if_id_pc), 0);
    chk({tag, " pc4"},       int'(if_id_pc_plus4), 0);
    chk({tag, " valid"},     int'(if_id_valid), 0);
    chk({tag, " fetch_cnt"}, int'(fetch_cnt), 0);
    chk({tag, " stall_cnt"}, int'(stall_cnt), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    chk_reset_state("por");

    // Free run from reset.
    step(0, 0, 0, 10'h000, 1, 10'h000);
    step(0, 0, 0, 10'h000, 1, 10'h004);
    step(0, 0, 0, 10'h000, 1, 10'h008);
    chk("run fetch_cnt", int'(fetch_cnt), 3);
    chk("run imem_addr", int'(imem_addr), 'h00C);

    // Load-use stall with 0x0BC in IF/ID.
    step(0, 0, 1, 10'h0BC, 0, 10'h000);
    step(0, 0, 0, 10'h000, 1, 10'h0BC);
    step(0, 1, 0, 10'h000, 1, 10'h0BC);
    chk("stall imem_addr", int'(imem_addr), 'h0C0);
    chk("stall stall_cnt", int'(stall_cnt), 1);
    step(0, 0, 0, 10'h000, 1, 10'h0C0);
    chk("stall fetch_cnt", int'(fetch_cnt), 5);

    // Branch redirect at pc 0x0DC to 0x0E0.
    step(0, 0, 1, 10'h0D8, 0, 10'h000);
    step(0, 0, 0, 10'h000, 1, 10'h0D8);
    chk("br pre imem_addr", int'(imem_addr), 'h0DC);
    step(0, 0, 1, 10'h0E0, 0, 10'h000);
    chk("br bubble fetch_cnt", int'(fetch_cnt), 6);
    step(0, 0, 0, 10'h000, 1, 10'h0E0);
    chk("br target fetch_cnt", int'(fetch_cnt), 7);

    // Stall and redirect together; aligned then misaligned target.
    step(0, 1, 1, 10'h100, 0, 10'h000);
    chk("sr imem_addr", int'(imem_addr), 'h100);
    chk("sr stall_cnt", int'(stall_cnt), 1);
    step(0, 0, 0, 10'h000, 1, 10'h100);
    step(0, 1, 1, 10'h102, 0, 10'h000);
    chk("sr mis imem_addr", int'(imem_addr), 'h100);
    chk("sr mis stall_cnt", int'(stall_cnt), 1);
    step(0, 0, 0, 10'h000, 1, 10'h100);

    // Redirect to the current PC still costs one bubble.
    step(0, 0, 1, 10'h104, 0, 10'h000);
    step(0, 0, 0, 10'h000, 1, 10'h104);
    chk("self fetch_cnt", int'(fetch_cnt), 10);

    // PC wrap at the top of memory.
    step(0, 0, 1, 10'h3FC, 0, 10'h000);
    step(0, 0, 0, 10'h000, 1, 10'h3FC);
    step(0, 0, 0, 10'h000, 1, 10'h000);
    chk("wrap imem_addr", int'(imem_addr), 'h004);
    chk("wrap fetch_cnt", int'(fetch_cnt), 12);

    // Reset during a stall (with a pending redirect) wins.
    step(1, 1, 1, 10'h200, 0, 10'h000);
    chk_reset_state("mid");
    step(0, 0, 0, 10'h000, 1, 10'h000);
    chk("post rst imem_addr", int'(imem_addr), 'h004);

    // Long stall: stall_cnt must saturate, not wrap.
    for (int i = 0; i < 65540; i++)
      step(0, 1, 0, 10'h000, 1, 10'h000);
    chk("sat stall_cnt", int'(stall_cnt), 'hFFFF);
    chk("sat fetch_cnt", int'(fetch_cnt), 1);
    chk("sat imem_addr", int'(imem_addr), 'h004);

    stall = 1'b0;
    @(negedge clk); #2;
    chk("scoreboard drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage RISC pipeline. Owns the program counter, drives the byte address into the combinational instruction memory, and captures the returned word into the IF/ID pipeline register. Handles load-use stalls from the hazard unit, and branch/jump redirects with a one-bubble flush. Keeps saturating fetch and stall counters for bring-up waveforms.

## Interface
- `ADDR_W`, 10: byte-address width of instruction memory (256 words).
- `RESET_PC`, 0: PC value after reset; word-aligned.
- `CNT_W`, 16: width of the performance counters.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard-unit hold: freeze PC and IF/ID.
- `redirect_valid`  in  1  taken branch or jump resolved downstream.
- `redirect_pc`  in  ADDR_W  target byte address; bits [1:0] ignored.
- `imem_addr`  out  ADDR_W  byte address to instruction memory, equal to the current PC.
- `imem_data`  in  32  combinational instruction word from memory.
- `if_id_instr`  out  32  latched instruction.
- `if_id_pc`  out  ADDR_W  address of the latched instruction.
- `if_id_pc_plus4`  out  ADDR_W  `if_id_pc + 4`, modulo 2^ADDR_W.
- `if_id_valid`  out  1  IF/ID holds a real instruction (0 = bubble).
- `fetch_cnt`  out  CNT_W  instructions latched as valid.
- `stall_cnt`  out  CNT_W  cycles lost to stall.

## Operation
- State consists of:
  - `pc`.
  - The IF/ID register: instruction, pc, pc_plus4 and valid.
  - Two counters.
- `imem_addr = pc` combinationally. Memory indexes by `pc[ADDR_W-1:2]`.
- Per-edge priority is reset > redirect > stall > advance.
  - **reset**:
    - `pc <= RESET_PC`.
    - IF/ID instr <= NOP (`32'h0`), pc and pc_plus4 <= 0, valid <= 0.
    - Both counters <= 0.
  - **redirect** (`redirect_valid`=1, regardless of `stall`):
    - `pc <= {redirect_pc[ADDR_W-1:2], 2'b00}`.
    - IF/ID <= bubble: NOP, valid 0, pc fields 0.
    - Redirect overrides a coincident stall; the stalled instruction is squashed.
  - **stall** (no redirect):
    - `pc` and all IF/ID fields hold their values.
    - `stall_cnt` += 1.
  - **advance**:
    - IF/ID instr <= `imem_data`; pc <= `pc`; pc_plus4 <= `pc+4`; valid <= 1.
    - `pc <= pc + 4`.
    - `fetch_cnt` += 1.
- PC arithmetic is modulo 2^ADDR_W: `0x3FC + 4 -> 0x000`. No fault is raised on wrap.
- Counters saturate at all-ones and never wrap.
- A redirect to the current PC is legal. It still inserts one bubble.

## Timing
- Fetch latency: an instruction at PC p appears on `if_id_instr` one cycle after `pc == p`, on the edge where advance occurs.
- Redirect penalty from this stage: exactly one bubble cycle.
  - In the cycle after the redirect edge, `if_id_valid = 0`.
  - The target instruction is valid one cycle after that.
  - Any upstream flush of older stages is the hazard unit's job.
- `stall` is sampled on the same edge it applies to. A 1-cycle stall holds IF/ID for exactly one extra cycle.
- All outputs are registered except `imem_addr`, which is a direct copy of the `pc` register.
- Reset values:
  - `imem_addr = RESET_PC`.
  - `if_id_instr = 0`, `if_id_pc = 0`, `if_id_pc_plus4 = 0`, `if_id_valid = 0`.
  - `fetch_cnt = 0`, `stall_cnt = 0`.
- Reset asserted mid-stream takes effect on the next edge. It discards any pending redirect or stall.

## Structure
- Shared package `cpu_pkg` holds:
  - `IMEM_ADDR_W` = 10.
  - `INSTR_W` = 32.
  - `NOP_INSTR` = `32'h0`.
  - `RESET_PC`.
  - The opcode constants used by decode.
- One sub-module: `sat_counter` (parameter width, inputs `clk`/`reset`/`inc`, output count), instantiated twice.
- The IF/ID register is inline, not a separate module.

## Test plan
- **Reset then free-run:** deassert `reset` and run 3 cycles with no stall or redirect.
  - `if_id_pc` sequence: 0x000, 0x004, 0x008.
  - `if_id_instr` equals the memory words at 0, 4, 8.
  - `fetch_cnt = 3`.
  - `imem_addr = 0x00C`.
- **Load-use stall:** assert `stall` for 1 cycle while `if_id_pc = 0x0BC`.
  - `pc` holds at 0x0C0 for one extra cycle.
  - `if_id_instr` is unchanged for 2 cycles.
  - `stall_cnt = 1`.
  - Next valid `if_id_pc` is 0x0C0.
- **Branch redirect:** pulse `redirect_valid` with `redirect_pc = 0x0E0` at pc 0x0DC.
  - Next cycle: `if_id_valid = 0` and `if_id_instr = 0`.
  - Following cycle: `if_id_pc = 0x0E0`, `valid = 1`.
  - `fetch_cnt` does not increment on the bubble.
- **Stall and redirect in the same cycle:** assert both with `redirect_pc = 0x100` (misaligned variant `0x102`).
  - `pc` becomes 0x100.
  - IF/ID is a bubble.
  - `stall_cnt` is unchanged.
- **Wrap:** redirect to 0x3FC, then advance 2 cycles.
  - `if_id_pc` sequence: 0x3FC then 0x000.
  - `if_id_pc_plus4` for 0x3FC is 0x000.
- **Reset mid-run and saturation:**
  - Assert `reset` during a stall: all outputs take their reset values next cycle.
  - Separately, hold `stall` for 65,540 cycles: `stall_cnt` stays at 0xFFFF.
